// File: rtl/mips_mc_control.sv
// mips_mc_control: main sequencer for the multicycle MIPS datapath
//   inputs : clk, reset (sync, active-high), opcode = IR[31:26], funct = IR[5:0],
//            zero (ALU zero flag), mem_ready (memory access completes this cycle)
//   outputs: pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
//            reg_write, alu_src_a, alu_src_b[1:0], pc_source[1:0], alu_ctrl[3:0],
//            illegal_op (one-cycle pulse), state[3:0] (debug)
module mips_mc_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [3:0] alu_ctrl,
    output logic       illegal_op,
    output logic [3:0] state
);
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB,
        BRANCH, ADDI_EX, ADDI_WB, JUMP
    } state_t;
    state_t st, nxt;
    always_ff @(posedge clk)
        if (reset) st <= FETCH;
        else st <= nxt;
    assign state = st;
    always_comb begin
        nxt = FETCH;
        pc_en = 1'b0;
        iord = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        ir_write = 1'b0;
        reg_dst = 1'b0;
        mem_to_reg = 1'b0;
        reg_write = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        pc_source = 2'b00;
        alu_ctrl = ALU_ADD;
        illegal_op = 1'b0;
        case (st)
            FETCH: begin
                mem_read = 1'b1;
                alu_src_b = 2'b01;
                ir_write = mem_ready;
                pc_en = mem_ready;
                nxt = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:   nxt = MEMADR;
                    OP_R:           nxt = EXEC;
                    OP_BEQ, OP_BNE: nxt = BRANCH;
                    OP_ADDI:        nxt = ADDI_EX;
                    OP_J:           nxt = JUMP;
                    default:        illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // opcode bit 3 separates sw (101011) from lw (100011)
                nxt = opcode[3] ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord = 1'b1;
                nxt = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord = 1'b1;
                nxt = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                nxt = ALUWB;
                case (funct)
                    6'b100000: alu_ctrl = ALU_ADD;
                    6'b100010: alu_ctrl = ALU_SUB;
                    6'b100100: alu_ctrl = ALU_AND;
                    6'b100101: alu_ctrl = ALU_OR;
                    6'b101010: alu_ctrl = ALU_SLT;
                    6'b100111: alu_ctrl = ALU_NOR;
                    default: begin
                        illegal_op = 1'b1;
                        nxt = FETCH;
                    end
                endcase
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl = ALU_SUB;
                pc_source = 2'b01;
                // opcode bit 0 set means bne
                pc_en = zero ^ opcode[0];
            end
            ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt = ADDI_WB;
            end
            ADDI_WB: reg_write = 1'b1;
            JUMP: begin
                pc_en = 1'b1;
                pc_source = 2'b10;
            end
            default: nxt = FETCH;
        endcase
        // reset abandons the current instruction with no partial writes
        if (reset) begin
            pc_en = 1'b0;
            mem_read = 1'b0;
            mem_write = 1'b0;
            ir_write = 1'b0;
            reg_write = 1'b0;
            illegal_op = 1'b0;
        end
    end
endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: table-driven check of the multicycle MIPS sequencer
module tb_mips_mc_control;
    localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2b, BEQ = 6'h04,
                           BNE = 6'h05, ADDI = 6'h08, J = 6'h02, BAD = 6'h3f;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24,
                           F_OR = 6'h25, F_SLT = 6'h2a, F_NOR = 6'h27, F_BAD = 6'h01;
    localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010,
                           A_SUB = 4'b0110, A_SLT = 4'b0111, A_NOR = 4'b1100;
    logic clk = 1'b0, reset, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_ctrl, state;
    int compared = 0, mismatched = 0;
    always #5 clk = ~clk;
    mips_mc_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_ctrl(alu_ctrl),
        .illegal_op(illegal_op), .state(state)
    );
    // {state, pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
    //  reg_write, alu_src_a, alu_src_b, pc_source, alu_ctrl, illegal_op}
    wire [21:0] act = {state, pc_en, iord, mem_read, mem_write, ir_write, reg_dst,
                       mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source, alu_ctrl, illegal_op};
    typedef struct {
        logic rst;
        logic [5:0] op, fn;
        logic z, mr;
        logic [21:0] exp;
    } vec_t;
    vec_t v[$];
    function automatic vec_t mk(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                                input logic z, input logic mr, input logic [3:0] st,
                                input logic pe, input logic io, input logic mrd, input logic mw,
                                input logic irw, input logic rd, input logic m2r, input logic rw,
                                input logic asa, input logic [1:0] asb, input logic [1:0] pcs,
                                input logic [3:0] alu, input logic ill);
        vec_t r;
        r.rst = rst; r.op = op; r.fn = fn; r.z = z; r.mr = mr;
        r.exp = {st, pe, io, mrd, mw, irw, rd, m2r, rw, asa, asb, pcs, alu, ill};
        return r;
    endfunction
    task automatic chk(input string name, input logic [21:0] a, input logic [21:0] e);
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic alu_seq(input logic [5:0] fn, input logic [3:0] alu);
        opcode = R; funct = fn; mem_ready = 1'b1;
        #1 chk("alu_fetch_state", {18'd0, state}, 22'd0);
        step();
        step();
        #1 chk("alu_exec", {14'd0, state, alu_ctrl}, {14'd0, 4'd6, alu});
        step();
        #1 chk("alu_wb", {18'd0, state, reg_write, reg_dst}, {18'd0, 4'd7, 2'b11});
        step();
    endtask
    initial begin
        reset = 1'b1; opcode = R; funct = F_SUB; zero = 1'b0; mem_ready = 1'b1;
        //                 rst op   fn     z  mr  st  pe io mr mw ir rd m2 rw a  asb    pcs    alu    ill
        v.push_back(mk(1, R,   F_SUB, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, A_ADD, 0));
        v.push_back(mk(1, R,   F_SUB, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, A_ADD, 0));
        v.push_back(mk(0, R,   F_SUB, 0, 1, 0,  1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, A_ADD, 0));
        v.push_back(mk(0, R,   F_SUB, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, A_ADD, 0));
        v.push_back(mk(0, R,   F_SUB, 0, 1, 6,  0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, A_SUB, 0));
        v.push_back(mk(0, R,   F_SUB, 0, 1, 7,  0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, A_ADD, 0));
        v.push_back(mk(0, LW,  F_SUB, 0, 1, 0,  1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, A_ADD, 0));
        v.push_back(mk(0, LW,  F_SUB, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, A_ADD, 0));
        v.push_back(mk(0, LW,  F_SUB, 0, 1, 2,  0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, A_ADD, 0));
        v.push_back(mk(0, LW,  F_SUB, 0, 0, 3,  0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, A_ADD, 0));
        v.push_back(mk(0, LW,  F_SUB, 0, 0, 3,  0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, A_ADD, 0));
        v.push_back(mk(0, LW,  F_SUB, 0, 1, 3,  0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, A_ADD, 0));
        v.push_back(mk(0, LW,  F_SUB, 0, 1, 4,  0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, A_ADD, 0));
        v.push_back(mk(0, SW,  F_SUB, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, A_ADD, 0));
        v.push_back(mk(0, SW,  F_SUB, 0, 1, 0,  1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, A_ADD, 0));
        v.push_back(mk(0, SW,  F_SUB, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, A_ADD, 0));
        v.push_back(mk(0, SW,  F_SUB, 0, 1, 2,  0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, A_ADD, 0));
        v.push_back(mk(0, SW,  F_SUB, 0, 1, 5,  0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, A_ADD, 0));
        v.push_back(mk(0, BEQ, F_SUB, 1, 1, 0,  1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, A_ADD, 0));
        v.push_back(mk(0, BEQ, F_SUB, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, A_ADD, 0));
        v.push_back(mk(0, BEQ, F_SUB, 1, 1, 8,  1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, A_SUB, 0));
        v.push_back(mk(0, BNE, F_SUB, 1, 1, 0,  1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, A_ADD, 0));
        v.push_back(mk(0, BNE, F_SUB, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, A_ADD, 0));
        v.push_back(mk(0, BNE, F_SUB, 1, 1, 8,  0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, A_SUB, 0));
        v.push_back(mk(0, BNE, F_SUB, 0, 1, 0,  1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, A_ADD, 0));
        v.push_back(mk(0, BNE, F_SUB, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, A_ADD, 0));
        v.push_back(mk(0, BNE, F_SUB, 0, 1, 8,  1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, A_SUB, 0));
        v.push_back(mk(0, ADDI,F_SUB, 0, 1, 0,  1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, A_ADD, 0));
        v.push_back(mk(0, ADDI,F_SUB, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, A_ADD, 0));
        v.push_back(mk(0, ADDI,F_SUB, 0, 1, 9,  0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, A_ADD, 0));
        v.push_back(mk(0, ADDI,F_SUB, 0, 1, 10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, A_ADD, 0));
        v.push_back(mk(0, J,   F_SUB, 0, 1, 0,  1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, A_ADD, 0));
        v.push_back(mk(0, J,   F_SUB, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, A_ADD, 0));
        v.push_back(mk(0, J,   F_SUB, 0, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, A_ADD, 0));
        v.push_back(mk(0, BAD, F_SUB, 0, 1, 0,  1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, A_ADD, 0));
        v.push_back(mk(0, BAD, F_SUB, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, A_ADD, 1));
        v.push_back(mk(0, R,   F_BAD, 0, 1, 0,  1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, A_ADD, 0));
        v.push_back(mk(0, R,   F_BAD, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, A_ADD, 0));
        v.push_back(mk(0, R,   F_BAD, 0, 1, 6,  0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, A_ADD, 1));
        v.push_back(mk(0, R,   F_AND, 0, 1, 0,  1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, A_ADD, 0));
        v.push_back(mk(0, R,   F_AND, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, A_ADD, 0));
        v.push_back(mk(0, R,   F_AND, 0, 1, 6,  0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, A_AND, 0));
        v.push_back(mk(0, R,   F_AND, 0, 1, 7,  0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, A_ADD, 0));
        step();
        for (int i = 0; i < v.size(); i++) begin
            reset = v[i].rst; opcode = v[i].op; funct = v[i].fn; zero = v[i].z; mem_ready = v[i].mr;
            #1 chk($sformatf("row%0d", i), act, v[i].exp);
            step();
        end
        alu_seq(F_OR, A_OR);
        alu_seq(F_SLT, A_SLT);
        alu_seq(F_NOR, A_NOR);
        alu_seq(F_ADD, A_ADD);
        opcode = SW; mem_ready = 1'b1;
        step();
        step();
        mem_ready = 1'b0;
        step();
        step();
        #1 chk("memwr_wait", {16'd0, state, mem_write, iord}, {16'd0, 4'd5, 2'b11});
        reset = 1'b1;
        #1 chk("memwr_reset_now", {19'd0, mem_write, reg_write, pc_en}, 22'd0);
        step();
        #1 chk("memwr_reset_state", {18'd0, state}, 22'd0);
        reset = 1'b0; mem_ready = 1'b1;
        #1 chk("post_reset_fetch", {19'd0, mem_read, ir_write, pc_en}, {19'd0, 3'b111});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
Main sequencer for the multicycle MIPS datapath. It decodes the opcode and funct fields held in the instruction register and steps through fetch, decode, execute, memory and writeback states. Each state drives the datapath mux selects, the write enables and the 4-bit ALU operation code. It also waits on a memory-ready handshake and resolves beq/bne using the ALU zero flag.

Parameters:
ALU_AND, 4'b0000, ALU code for AND
ALU_OR, 4'b0001, ALU code for OR
ALU_ADD, 4'b0010, ALU code for ADD
ALU_SUB, 4'b0110, ALU code for SUB
ALU_SLT, 4'b0111, ALU code for set-less-than
ALU_NOR, 4'b1100, ALU code for NOR

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
opcode  input  6  IR[31:26]
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag
mem_ready  input  1  memory access completes this cycle
pc_en  output  1  PC load enable
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
ir_write  output  1  IR load enable
reg_dst  output  1  register destination select: 0 = rt, 1 = rd
mem_to_reg  output  1  writeback data select: 0 = ALUOut, 1 = MDR
reg_write  output  1  register file write enable
alu_src_a  output  1  ALU A select: 0 = PC, 1 = A register
alu_src_b  output  2  ALU B select: 00 = B register, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
pc_source  output  2  PC source select: 00 = ALU result, 01 = ALUOut, 10 = jump target
alu_ctrl  output  4  operation code to ALU
illegal_op  output  1  one-cycle pulse on unsupported opcode or funct
state  output  4  current state, for debug

Behaviour:
- State register is the only sequential element. All outputs are combinational from state (plus funct in EXEC, zero and mem_ready where noted).
- Defaults when a state does not list a signal: all enables 0, all selects 0, alu_ctrl = ALU_ADD.
- Reset: while reset = 1, every write or strobe output is forced to 0 (pc_en, mem_read, mem_write, ir_write, reg_write, illegal_op). On the next rising edge, state = FETCH (0). Reset asserted mid-instruction abandons that instruction with no partial writes.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010.

State actions and transitions:
- FETCH(0): mem_read = 1, alu_src_b = 01, ADD. ir_write and pc_en equal mem_ready. Hold in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
- DECODE(1): alu_src_b = 11, ADD (precomputes branch target into ALUOut). Next state by opcode:
  - lw or sw -> MEMADR
  - R-type -> EXEC
  - beq or bne -> BRANCH
  - addi -> ADDI_EX
  - j -> JUMP
  - any other opcode -> FETCH, with illegal_op = 1 this cycle
- MEMADR(2): alu_src_a = 1, alu_src_b = 10, ADD. Go to MEMRD for lw, MEMWR for sw.
- MEMRD(3): mem_read = 1, iord = 1. Hold until mem_ready = 1, then go to MEMWB.
- MEMWB(4): reg_write = 1, mem_to_reg = 1, reg_dst = 0. Go to FETCH.
- MEMWR(5): mem_write = 1, iord = 1. Hold until mem_ready = 1, then go to FETCH. mem_write stays asserted throughout the wait.
- EXEC(6): alu_src_a = 1, alu_src_b = 00. alu_ctrl from funct:
  - 100000 -> ADD
  - 100010 -> SUB
  - 100100 -> AND
  - 100101 -> OR
  - 101010 -> SLT
  - 100111 -> NOR
  - any other funct -> alu_ctrl = ADD, illegal_op = 1, next state FETCH (skip ALUWB)
  - Otherwise go to ALUWB.
- ALUWB(7): reg_write = 1, reg_dst = 1. Go to FETCH.
- BRANCH(8): alu_src_a = 1, alu_src_b = 00, SUB, pc_source = 01. pc_en = zero for beq, ~zero for bne (opcode bit 0 selects). Go to FETCH.
- ADDI_EX(9): alu_src_a = 1, alu_src_b = 10, ADD. Go to ADDI_WB.
- ADDI_WB(10): reg_write = 1, reg_dst = 0. Go to FETCH.
- JUMP(11): pc_en = 1, pc_source = 10. Go to FETCH.
- Codes 12–15 are unreachable. If entered, the block goes to FETCH on the next cycle with all enables 0.

Latency with mem_ready held at 1:
- lw: 5 cycles
- R-type, sw, addi: 4 cycles
- beq, bne, j: 3 cycles
Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.

Test Plan:
- Reset held for 3 cycles, then released, mem_ready = 1 -> state = 0 the first cycle after release; mem_read = 1, ir_write = 1, pc_en = 1; no writes while reset = 1.
- opcode 000000, funct 100010, mem_ready = 1 -> states 0,1,6,7,0; alu_ctrl = 4'b0110 in EXEC; reg_write = 1 and reg_dst = 1 in ALUWB only.
- lw (100011) with mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; iord = 1 during MEMRD; mem_to_reg = 1 in MEMWB.
- beq with zero = 1, then bne with zero = 1 -> pc_en = 1 in BRANCH for beq, pc_en = 0 for bne; pc_source = 01 in both.
- opcode 111111 -> illegal_op pulses for 1 cycle in DECODE, next state 0, no reg_write or mem_write; funct 000001 gives the same outcome from EXEC.
- Reset asserted during MEMWR with mem_ready = 0 -> mem_write = 0 immediately; state = 0 after the edge.
